// File: rtl/tx_send_scheduler_pkg.sv
// Shared types and width helpers for the TX send scheduler and its round-robin arbiter.
package tx_send_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } tx_sched_state_t;

  // Index width for an N-entry table; a single entry still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int max_count);
    return (max_count > 0) ? $clog2(max_count + 1) : 1;
  endfunction

endpackage

// File: rtl/tx_send_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
// Zero latency; no backpressure, the caller decides whether to consume the grant.
module tx_send_scheduler_rr_arbiter
  import tx_send_scheduler_pkg::*;
#(
  parameter int  N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    // Upper pass covers [ptr, N-1]; lower pass wraps to [0, ptr-1].
    for (int i = 0; i < N; i++) begin
      if (!grant_vld && req[i] && (i >= int'(ptr))) begin
        grant_vld = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!grant_vld && req[i]) begin
        grant_vld = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/tx_send_scheduler.sv
// Queues per-slot send triggers and issues them round-robin to tx_fsm; trigger-to-start 2 cycles.
// send_start holds until send_ack; a WAIT_DONE without send_done aborts after TIMEOUT cycles.
module tx_send_scheduler
  import tx_send_scheduler_pkg::*;
#(
  parameter int  NUM_MSGS   = 4,
  parameter int  GAP_CYCLES = 2,
  parameter int  TIMEOUT    = 1024,
  localparam int ID_W       = idx_width(NUM_MSGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trig_valid,
  input  logic [ID_W-1:0]     trig_id,
  output logic                trig_err,
  output logic                send_start,
  output logic [ID_W-1:0]     send_id,
  input  logic                send_ack,
  input  logic                send_done,
  output logic                send_abort,
  output logic [NUM_MSGS-1:0] pending,
  output logic                busy,
  output logic                timeout_err,
  input  logic                err_clr
);

  localparam int                TO_W     = cnt_width(TIMEOUT);
  localparam int                GAP_W    = cnt_width(GAP_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(NUM_MSGS - 1);
  localparam tx_sched_state_t   POST_PKT = (GAP_CYCLES == 0) ? IDLE : GAP;

  tx_sched_state_t     state;
  logic [TO_W-1:0]     to_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [ID_W-1:0]     rr_ptr;

  logic [NUM_MSGS-1:0] grant_oh;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_vld;
  logic                grant_take;
  logic [ID_W-1:0]     rr_ptr_nxt;

  logic [NUM_MSGS-1:0] trig_oh;
  logic [NUM_MSGS-1:0] clr_mask;
  logic [NUM_MSGS-1:0] set_mask;
  logic                trig_in_range;
  logic                trig_dup;
  logic                trig_ok;

  tx_send_scheduler_rr_arbiter #(
    .N(NUM_MSGS)
  ) u_arb (
    .req       (pending),
    .ptr       (rr_ptr),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign grant_take = (state == IDLE) && grant_vld;
  assign clr_mask   = grant_take ? grant_oh : '0;
  assign rr_ptr_nxt = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;

  // Decoding the id into a one-hot also yields the range check, without indexing out of bounds.
  always_comb begin
    trig_oh = '0;
    for (int i = 0; i < NUM_MSGS; i++) begin
      trig_oh[i] = (int'(trig_id) == i);
    end
  end

  // A slot being granted this cycle counts as in flight, so re-triggering it is legal.
  assign trig_in_range = |trig_oh;
  assign trig_dup      = |(trig_oh & pending & ~clr_mask);
  assign trig_ok       = trig_valid && trig_in_range && !trig_dup;
  assign set_mask      = trig_ok ? trig_oh : '0;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      rr_ptr      <= '0;
      send_start  <= 1'b0;
      send_id     <= '0;
      trig_err    <= 1'b0;
      send_abort  <= 1'b0;
      timeout_err <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      pending    <= (pending & ~clr_mask) | set_mask;
      trig_err   <= trig_valid && !trig_ok;
      send_abort <= 1'b0;
      if (err_clr) begin
        timeout_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (grant_vld) begin
            send_id    <= grant_idx;
            rr_ptr     <= rr_ptr_nxt;
            send_start <= 1'b1;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          if (send_ack) begin
            send_start <= 1'b0;
            to_cnt     <= '0;
            state      <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (send_done) begin
            gap_cnt <= '0;
            state   <= POST_PKT;
          end else if (to_cnt == TO_LAST) begin
            // Overrides a same-cycle err_clr: the later assignment wins.
            send_abort  <= 1'b1;
            timeout_err <= 1'b1;
            gap_cnt     <= '0;
            state       <= POST_PKT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_send_scheduler.sv
// Directed bench for tx_send_scheduler: expected issue ids queue up as triggers are driven.
module tb_tx_send_scheduler;

  localparam int NUM = 4;
  localparam int GAP_N = 2;
  localparam int TO_N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig_valid = 1'b0;
  logic [1:0] trig_id = '0;
  logic       trig_err;
  logic       send_start;
  logic [1:0] send_id;
  logic       send_ack = 1'b0;
  logic       send_done = 1'b0;
  logic       send_abort;
  logic [3:0] pending;
  logic       busy;
  logic       timeout_err;
  logic       err_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int sbq[$];

  always #5 clk = ~clk;

  tx_send_scheduler #(
    .NUM_MSGS  (NUM),
    .GAP_CYCLES(GAP_N),
    .TIMEOUT   (TO_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig_valid (trig_valid),
    .trig_id    (trig_id),
    .trig_err   (trig_err),
    .send_start (send_start),
    .send_id    (send_id),
    .send_ack   (send_ack),
    .send_done  (send_done),
    .send_abort (send_abort),
    .pending    (pending),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic trig(input logic [1:0] id);
    trig_valid = 1'b1;
    trig_id    = id;
    step();
    trig_valid = 1'b0;
  endtask

  // Waits (bounded) for send_start, compares send_id with the scoreboard head, then acks.
  task automatic issue_and_ack(input string tag, output int wait_n);
    logic [31:0] exp_id;
    wait_n = 0;
    while (!send_start && wait_n < 40) begin
      step();
      wait_n++;
    end
    check({tag, "_start_seen"}, {31'd0, send_start}, 32'd1);
    check({tag, "_sb_nonempty"}, {31'd0, (sbq.size() > 0)}, 32'd1);
    exp_id = (sbq.size() > 0) ? 32'(sbq.pop_front()) : 32'hFFFF_FFFF;
    check({tag, "_send_id"}, {30'd0, send_id}, exp_id);
    send_ack = 1'b1;
    step();
    send_ack = 1'b0;
    check({tag, "_start_drop"}, {31'd0, send_start}, 32'd0);
  endtask

  task automatic finish_pkt();
    send_done = 1'b1;
    step();
    send_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;

    // Reset values
    step();
    step();
    check("rst_pending", {28'd0, pending}, 32'd0);
    check("rst_start", {31'd0, send_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_toerr", {31'd0, timeout_err}, 32'd0);
    check("rst_send_id", {30'd0, send_id}, 32'd0);
    rst = 1'b0;
    step();

    // 1: single send of id 2 with gap timing
    sbq.push_back(2);
    trig(2'd2);
    check("t1_pending", {28'd0, pending}, 32'h4);
    check("t1_no_start_yet", {31'd0, send_start}, 32'd0);
    step();
    check("t1_start_next", {31'd0, send_start}, 32'd1);
    issue_and_ack("t1", n);
    check("t1_wait_n", 32'(n), 32'd0);
    check("t1_pending_ack", {28'd0, pending}, 32'd0);
    check("t1_busy_ack", {31'd0, busy}, 32'd1);
    finish_pkt();
    check("t1_gap1_busy", {31'd0, busy}, 32'd1);
    step();
    check("t1_gap2_busy", {31'd0, busy}, 32'd1);
    step();
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    send_ack  = 1'b1;
    send_done = 1'b1;
    step();
    send_ack  = 1'b0;
    send_done = 1'b0;
    check("t1_stray_busy", {31'd0, busy}, 32'd0);
    check("t1_stray_start", {31'd0, send_start}, 32'd0);

    // 2: round-robin order 3,0,1 after id 2 (rr_ptr=3)
    sbq.push_back(2);
    trig(2'd2);
    issue_and_ack("t2a", n);
    sbq.push_back(3);
    sbq.push_back(0);
    sbq.push_back(1);
    trig(2'd0);
    trig(2'd1);
    trig(2'd3);
    check("t2_pending", {28'd0, pending}, 32'hB);
    finish_pkt();
    issue_and_ack("t2b", n);
    check("t2_done_to_start", 32'(n + 1), 32'(GAP_N + 2));
    finish_pkt();
    issue_and_ack("t2c", n);
    finish_pkt();
    issue_and_ack("t2d", n);
    finish_pkt();
    repeat (4) step();

    // 3: duplicate trigger while pending is rejected
    sbq.push_back(0);
    trig(2'd0);
    issue_and_ack("t3a", n);
    sbq.push_back(1);
    trig(2'd1);
    check("t3_first_ok", {31'd0, trig_err}, 32'd0);
    trig(2'd1);
    check("t3_dup_err", {31'd0, trig_err}, 32'd1);
    check("t3_pending", {28'd0, pending}, 32'h2);
    step();
    check("t3_err_pulse", {31'd0, trig_err}, 32'd0);
    finish_pkt();
    issue_and_ack("t3b", n);
    finish_pkt();
    seen = 1'b0;
    repeat (8) begin
      step();
      seen = seen | send_start;
    end
    check("t3_single_send", {31'd0, seen}, 32'd0);
    check("t3_pending_end", {28'd0, pending}, 32'd0);

    // 4: re-trigger of in-flight slot, and re-trigger on the grant cycle
    sbq.push_back(2);
    trig(2'd2);
    issue_and_ack("t4a", n);
    sbq.push_back(2);
    trig(2'd2);
    check("t4_inflight_pend", {28'd0, pending}, 32'h4);
    check("t4_inflight_err", {31'd0, trig_err}, 32'd0);
    finish_pkt();
    issue_and_ack("t4b", n);
    finish_pkt();
    repeat (4) step();
    check("t4_idle", {31'd0, busy}, 32'd0);
    sbq.push_back(0);
    sbq.push_back(0);
    trig_valid = 1'b1;
    trig_id    = 2'd0;
    step();
    step();
    trig_valid = 1'b0;
    check("t4_grant_cycle_pend", {28'd0, pending}, 32'h1);
    check("t4_grant_cycle_err", {31'd0, trig_err}, 32'd0);
    issue_and_ack("t4c", n);
    finish_pkt();
    issue_and_ack("t4d", n);
    finish_pkt();
    repeat (4) step();

    // 5: timeout abort 16 cycles after ack; err_clr loses to a same-cycle abort
    sbq.push_back(3);
    trig(2'd3);
    issue_and_ack("t5a", n);
    repeat (TO_N - 1) step();
    check("t5_no_early_abort", {31'd0, send_abort}, 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_abort_at_16", {31'd0, send_abort}, 32'd1);
    check("t5_set_wins", {31'd0, timeout_err}, 32'd1);
    step();
    check("t5_abort_pulse", {31'd0, send_abort}, 32'd0);
    check("t5_sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_cleared", {31'd0, timeout_err}, 32'd0);
    sbq.push_back(3);
    trig(2'd3);
    issue_and_ack("t5b", n);
    repeat (TO_N - 1) step();
    finish_pkt();
    check("t5_done_wins_abort", {31'd0, send_abort}, 32'd0);
    check("t5_done_wins_err", {31'd0, timeout_err}, 32'd0);
    check("t5_done_gap_busy", {31'd0, busy}, 32'd1);
    step();
    check("t5_no_late_abort", {31'd0, send_abort}, 32'd0);
    repeat (4) step();

    // 6: asynchronous reset mid-packet flushes everything
    sbq.push_back(2);
    trig(2'd2);
    issue_and_ack("t6a", n);
    trig(2'd1);
    trig(2'd3);
    check("t6_pending_pre", {28'd0, pending}, 32'hA);
    check("t6_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_pending", {28'd0, pending}, 32'd0);
    check("t6_async_busy", {31'd0, busy}, 32'd0);
    check("t6_async_send_id", {30'd0, send_id}, 32'd0);
    check("t6_async_start", {31'd0, send_start}, 32'd0);
    check("t6_async_abort", {31'd0, send_abort}, 32'd0);
    check("t6_async_trig_err", {31'd0, trig_err}, 32'd0);
    sbq.delete();
    step();
    step();
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      step();
      seen = seen | send_start;
    end
    check("t6_no_start_after", {31'd0, seen}, 32'd0);
    check("t6_pending_after", {28'd0, pending}, 32'd0);
    sbq.push_back(1);
    trig(2'd1);
    issue_and_ack("t6b", n);
    finish_pkt();
    repeat (4) step();
    check("end_sb_empty", 32'(sbq.size()), 32'd0);
    check("end_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
